// File: rtl/shift_register.sv
// WIDTH-bit universal shift register (hold / shift left / shift right / load) with a saturating shift counter.
// Optional feature: define SHIFTREG_ROTATE_EN to add the ROT input, which turns shifts into rotates.
module shift_register #(
   parameter int WIDTH = 4
) (
   input  logic                         C,
   input  logic                         _R,
   input  logic [1:0]                   M,
   input  logic [WIDTH-1:0]             D,
   input  logic                         DL,
   input  logic                         DR,
   output logic [WIDTH-1:0]             Q,
   output logic [WIDTH-1:0]             _Q,
   output logic                         SOL,
   output logic                         SOR,
   output logic [$clog2(WIDTH+1)-1:0]   CNT,
   output logic                         DONE
`ifdef SHIFTREG_ROTATE_EN
   ,
   input  logic                         ROT
`endif
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] FULL = CW'(WIDTH);

   typedef enum logic [1:0] {
      MODE_HOLD  = 2'b00,
      MODE_LEFT  = 2'b01,
      MODE_RIGHT = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_t;

   logic             rot;
   logic [WIDTH-1:0] q_next;
   logic [CW-1:0]    cnt_next;
   logic [CW-1:0]    cnt_inc;

`ifdef SHIFTREG_ROTATE_EN
   assign rot = ROT;
`else
   assign rot = 1'b0;
`endif

   // Left and right moves share one counter that sticks at WIDTH once a full word has passed.
   assign cnt_inc = (CNT == FULL) ? FULL : CNT + CW'(1);

   // An unknown mode matches no item and falls through to hold.
   always_comb begin
      q_next   = Q;
      cnt_next = CNT;
      case (M)
         MODE_LEFT: begin
            q_next   = {Q[WIDTH-2:0], (rot ? Q[WIDTH-1] : DL)};
            cnt_next = cnt_inc;
         end
         MODE_RIGHT: begin
            q_next   = {(rot ? Q[0] : DR), Q[WIDTH-1:1]};
            cnt_next = cnt_inc;
         end
         MODE_LOAD: begin
            q_next   = D;
            cnt_next = '0;
         end
         default: begin
            q_next   = Q;
            cnt_next = CNT;
         end
      endcase
   end

   // DONE is computed from the next count so it lines up with CNT on the same edge.
   always_ff @(posedge C or negedge _R) begin
      if (!_R) begin
         Q    <= '0;
         CNT  <= '0;
         DONE <= 1'b0;
      end else begin
         Q    <= q_next;
         CNT  <= cnt_next;
         DONE <= (cnt_next == FULL);
      end
   end

   assign _Q  = ~Q;
   assign SOL = Q[WIDTH-1];
   assign SOR = Q[0];

endmodule

// File: tb/tb_shift_register.sv
// Randomised and directed bench for shift_register against an arithmetic reference model.
// Build with SHIFTREG_ROTATE_EN defined to also exercise the rotate feature.
module tb_shift_register;

   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);
   localparam int VW = 2 * W + CW + 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    mode;
   logic [W-1:0]  d;
   logic          dl;
   logic          dr;
   logic          rot;
   logic [W-1:0]  q;
   logic [W-1:0]  q_bar;
   logic          sol;
   logic          sor;
   logic [CW-1:0] cnt;
   logic          done;

   int vectors     = 0;
   int miscompares = 0;

   logic [W-1:0]  m_q;
   int            m_cnt;
   logic          m_done;

   shift_register #(.WIDTH(W)) dut (
      .C    (clk),
      ._R   (rst_n),
      .M    (mode),
      .D    (d),
      .DL   (dl),
      .DR   (dr),
      .Q    (q),
      ._Q   (q_bar),
      .SOL  (sol),
      .SOR  (sor),
      .CNT  (cnt),
      .DONE (done)
`ifdef SHIFTREG_ROTATE_EN
      ,
      .ROT  (rot)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: the register is a number, shifts are multiply/divide by two.
   task automatic model_reset();
      m_q    = '0;
      m_cnt  = 0;
      m_done = 1'b0;
   endtask

   task automatic model_edge();
      case (mode)
         2'b01: begin
            if (rot) m_q = (m_q << 1) | (m_q >> (W - 1));
            else     m_q = (m_q << 1) | W'(dl);
            m_cnt = (m_cnt >= W) ? W : m_cnt + 1;
         end
         2'b10: begin
            if (rot) m_q = (m_q >> 1) | (m_q << (W - 1));
            else     m_q = (m_q >> 1) | (W'(dr) << (W - 1));
            m_cnt = (m_cnt >= W) ? W : m_cnt + 1;
         end
         2'b11: begin
            m_q   = d;
            m_cnt = 0;
         end
         default: ;
      endcase
      m_done = (m_cnt == W);
   endtask

   function automatic logic [VW-1:0] model_view();
      return {m_q, ~m_q, m_q[W-1], m_q[0], CW'(m_cnt), m_done};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mode = 2'b11; d = 4'hF; dl = 1'b0; dr = 1'b0; rot = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({q, q_bar, cnt, done} !== {4'b0000, 4'b1111, 3'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_initial: got q=%b q_bar=%b cnt=%0d done=%b, expected 0000/1111/0/0", q, q_bar, cnt, done);
      end
      repeat (2) tick();
      vectors++;
      if ({q, cnt, done} !== {4'b0000, 3'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_held: got q=%b cnt=%0d done=%b, expected 0000/0/0", q, cnt, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mode = 2'b11; d = 4'b1011;
      tick();
      vectors++;
      if (q !== 4'b1011) begin
         miscompares++;
         $display("[TB] FAIL reset_preload: got q=%b, expected 1011", q);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      vectors++;
      if ({q, q_bar, cnt, done} !== {4'b0000, 4'b1111, 3'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reset_async: got q=%b q_bar=%b cnt=%0d done=%b, expected 0000/1111/0/0", q, q_bar, cnt, done);
      end
      @(negedge clk);
      rst_n = 1'b1;
      mode = 2'b00;
   endtask

   task automatic test_load();
      mode = 2'b11; d = 4'b1010;
      tick();
      vectors++;
      if ({q, q_bar, sol, sor, cnt} !== {4'b1010, 4'b0101, 1'b1, 1'b0, 3'd0}) begin
         miscompares++;
         $display("[TB] FAIL load: got q=%b q_bar=%b sol=%b sor=%b cnt=%0d, expected 1010/0101/1/0/0", q, q_bar, sol, sor, cnt);
      end
   endtask

   task automatic test_shift_left();
      logic [W-1:0] exp_q   [4] = '{4'b0101, 4'b1011, 4'b0111, 4'b1111};
      logic         exp_sol [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      mode = 2'b01; dl = 1'b1;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (sol !== exp_sol[i]) begin
            miscompares++;
            $display("[TB] FAIL shl_sol[%0d]: got %b, expected %b", i, sol, exp_sol[i]);
         end
         tick();
         vectors++;
         if ({q, cnt, done} !== {exp_q[i], CW'(i + 1), (i == 3)}) begin
            miscompares++;
            $display("[TB] FAIL shl_step[%0d]: got q=%b cnt=%0d done=%b, expected q=%b cnt=%0d done=%b",
                     i, q, cnt, done, exp_q[i], i + 1, (i == 3));
         end
      end
      tick();
      vectors++;
      if ({q, cnt, done} !== {4'b1111, 3'd4, 1'b1}) begin
         miscompares++;
         $display("[TB] FAIL shl_saturate: got q=%b cnt=%0d done=%b, expected 1111/4/1", q, cnt, done);
      end
   endtask

   task automatic test_shift_right_hold();
      logic [W-1:0] exp_q [2] = '{4'b0101, 4'b0010};
      mode = 2'b11; d = 4'b1010;
      tick();
      mode = 2'b10; dr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++;
         if ({q, cnt} !== {exp_q[i], CW'(i + 1)}) begin
            miscompares++;
            $display("[TB] FAIL shr_step[%0d]: got q=%b cnt=%0d, expected q=%b cnt=%0d", i, q, cnt, exp_q[i], i + 1);
         end
      end
      mode = 2'b00; dr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if ({q, cnt, done} !== {4'b0010, 3'd2, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL hold[%0d]: got q=%b cnt=%0d done=%b, expected 0010/2/0", i, q, cnt, done);
         end
      end
   endtask

   task automatic test_reload();
      mode = 2'b01;
      for (int i = 0; i < 4; i++) begin
         dl = 1'($urandom);
         tick();
      end
      vectors++;
      if (done !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reload_pre_done: got %b, expected 1", done);
      end
      mode = 2'b11; d = 4'b0110;
      tick();
      vectors++;
      if ({q, cnt, done} !== {4'b0110, 3'd0, 1'b0}) begin
         miscompares++;
         $display("[TB] FAIL reload: got q=%b cnt=%0d done=%b, expected 0110/0/0", q, cnt, done);
      end
   endtask

`ifdef SHIFTREG_ROTATE_EN
   task automatic test_rotate();
      logic [W-1:0] exp_q [4] = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
      mode = 2'b11; d = 4'b1000;
      tick();
      mode = 2'b10; rot = 1'b1; dr = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         vectors++;
         if ({q, done} !== {exp_q[i], (i == 3)}) begin
            miscompares++;
            $display("[TB] FAIL rotate[%0d]: got q=%b done=%b, expected q=%b done=%b", i, q, done, exp_q[i], (i == 3));
         end
      end
      rot = 1'b0;
   endtask
`endif

   // Random modes and data every cycle, with occasional mid-cycle resets.
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         mode = 2'($urandom);
         d    = W'($urandom);
         dl   = 1'($urandom);
         dr   = 1'($urandom);
`ifdef SHIFTREG_ROTATE_EN
         rot  = 1'($urandom);
`else
         rot  = 1'b0;
`endif
         tick();
         vectors++;
         if ({q, q_bar, sol, sor, cnt, done} !== model_view()) begin
            miscompares++;
            $display("[TB] FAIL random[%0d]: got q=%b q_bar=%b sol=%b sor=%b cnt=%0d done=%b, expected view %b",
                     i, q, q_bar, sol, sor, cnt, done, model_view());
         end
         if ($urandom_range(31) == 0) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            vectors++;
            if ({q, q_bar, sol, sor, cnt, done} !== model_view()) begin
               miscompares++;
               $display("[TB] FAIL random_reset[%0d]: got q=%b cnt=%0d done=%b, expected 0/0/0", i, q, cnt, done);
            end
            #1;
            rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_shift_left();
      test_shift_right_hold();
      test_reload();
`ifdef SHIFTREG_ROTATE_EN
      test_rotate();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
